digit_scan_mux: RTL
===================

Name: digit_scan_mux

Overview:
- Time-multiplexed scan driver for a common-anode multi-digit seven-segment display.
- Sits directly upstream of the binary-to-seven-segment decoder. Takes the full multi-digit counter value and presents one 4-bit nibble at a time on digit_out, which feeds the decoder's bin_in.
- Drives the active-low digit anodes in step with the nibble.
- Inserts a blanking interval at the start of every digit slot to prevent ghosting.
- Snapshots the input once per frame so a changing count never tears across digits.

Parameters:
- NUM_DIGITS, 4: number of display digits (2..8).
- REFRESH_DIV, 100000: clock cycles per digit slot (>= 2).
- BLANK_CYCLES, 1000: cycles per slot with all anodes off. Must be < REFRESH_DIV; 0 disables blanking.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  scan enable; low blanks the display and idles the scanner.
- value_in  in  4*NUM_DIGITS  packed digits; nibble i = value_in[4i+3:4i], digit 0 least significant.
- digit_out  out  4  nibble currently scanned, to the decoder's bin_in.
- anode_n  out  NUM_DIGITS  active-low digit enables; bit i lights digit i.
- frame_start  out  1  one-cycle pulse when a new frame snapshot is taken.

Behaviour:
- Clock/reset: one clock (clk); reset rst_n is asynchronous, active-low.
- All outputs and state are registered.
- Reset values:
  - state = IDLE, prescaler = 0, idx = 0, frame register = 0.
  - digit_out = 4'h0, anode_n = all 1s, frame_start = 0.
- States are IDLE, BLANK, DRIVE.
- IDLE:
  - anode_n is all 1s; prescaler and idx are held at 0.
  - When enable = 1:
    - Snapshot value_in into the frame register.
    - Set idx = 0 and digit_out = nibble 0.
    - Pulse frame_start for one cycle.
    - Go to BLANK, or directly to DRIVE if BLANK_CYCLES = 0.
- BLANK:
  - anode_n is all 1s; prescaler increments.
  - When prescaler = BLANK_CYCLES-1, go to DRIVE.
- DRIVE:
  - anode_n[idx] = 0, all other bits 1; prescaler increments.
  - When prescaler = REFRESH_DIV-1:
    - Reset prescaler to 0 and advance idx.
    - If idx = NUM_DIGITS-1, wrap idx to 0, re-snapshot value_in, and pulse frame_start.
    - Load digit_out with frame nibble[new idx] on the same edge.
    - Go to BLANK, or stay in DRIVE if BLANK_CYCLES = 0.
- Slot length is exactly REFRESH_DIV cycles: BLANK_CYCLES with anodes off, then REFRESH_DIV-BLANK_CYCLES with the anode on.
- Frame period = NUM_DIGITS*REFRESH_DIV cycles.
- digit_out changes only on slot boundaries, so it is always stable while its anode is low.
- value_in changes mid-frame have no effect until the next wrap snapshot.
- enable = 0 in any state: on the next edge go to IDLE, drive anode_n all 1s, clear prescaler and idx, and hold digit_out. Re-enable always starts a fresh frame at digit 0.
- Simultaneous enable fall and slot wrap: enable takes priority. No snapshot, no frame_start.
- Reset asserted mid-slot immediately forces the reset values (asynchronous); the anodes go dark without waiting for a clock.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - At each snapshot, compute the index of the most significant nonzero nibble of the frame.
  - In DRIVE, digits with idx above that index keep anode_n[idx] = 1.
  - Digit 0 is always displayed, so a frame of all zeros shows a single "0".
  - Slot timing and frame_start are unchanged.
- Not defined: all digits are always driven, including leading zeros.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2):
- Reset, then enable=1, value_in=16'h1234:
  - frame_start pulses on the first edge.
  - Slot 0: digit_out=4, anode_n=1111 for 2 cycles, then 1110 for 6 cycles.
  - Slots 1..3 show 3, 2, 1 with anode_n 1101, 1011, 0111.
  - frame_start pulses again at cycle 32.
- Change value_in to 16'hABCD in the middle of slot 1: slots 2 and 3 still show 2 and 1. The next frame shows D, C, B, A.
- Drop enable in the middle of the DRIVE phase of slot 2: anode_n=1111 on the next edge. Re-enable: frame_start pulses, digit_out=nibble 0, and the scan restarts at slot 0.
- Assert rst_n=0 between clock edges during DRIVE: anode_n goes to 1111 and digit_out to 0 immediately. After release, the block stays in IDLE until enable is high.
- BLANK_CYCLES=0 build: anode_n is never all 1s while enabled. Each anode is low for 8 consecutive cycles.
- With LEADING_ZERO_BLANK_EN:
  - value_in=16'h0042: slots 2 and 3 keep anode_n=1111 through DRIVE.
  - value_in=16'h0000: only slot 0 lights, with digit_out=0.

Source files
------------

// File: rtl/digit_scan_mux.sv
// Scan driver for a common-anode multi-digit seven-segment display, one nibble per slot.
// Optional build macro LEADING_ZERO_BLANK_EN keeps leading-zero digits dark.
module digit_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  output logic [3:0]              digit_out,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic                    frame_start
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  // BLANK is unreachable when BLANK_CYCLES is 0; clamp keeps the constant legal.
  localparam logic [PW-1:0] BLANK_LAST = PW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t                  state_r, state_s;
  logic [PW-1:0]           presc_r, presc_s;
  logic [IW-1:0]           idx_r, idx_s;
  logic [4*NUM_DIGITS-1:0] frame_r, frame_s;
  logic [3:0]              digit_r, digit_s;
  logic [NUM_DIGITS-1:0]   anode_r, anode_s;
  logic                    fs_r, fs_s;

`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0]           lz_r, lz_s;

  function automatic logic [IW-1:0] msd_index(input logic [4*NUM_DIGITS-1:0] v);
    logic [IW-1:0] m;
    m = {IW{1'b0}};
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] != 4'h0) begin
        m = IW'(i);
      end else begin
        m = m;
      end
    end
    return m;
  endfunction
`endif

  // Next-state, counters, snapshot and output decode.
  always_comb begin
    state_s = state_r;
    presc_s = presc_r;
    idx_s   = idx_r;
    frame_s = frame_r;
    digit_s = digit_r;
    fs_s    = 1'b0;
    anode_s = {NUM_DIGITS{1'b1}};
`ifdef LEADING_ZERO_BLANK_EN
    lz_s    = lz_r;
`endif
    if (!enable) begin
      state_s = IDLE;
      presc_s = {PW{1'b0}};
      idx_s   = {IW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          presc_s = {PW{1'b0}};
          idx_s   = {IW{1'b0}};
          frame_s = value_in;
          digit_s = value_in[3:0];
          fs_s    = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
          lz_s    = msd_index(value_in);
`endif
          state_s = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
        end
        BLANK: begin
          presc_s = presc_r + PW'(1);
          if (presc_r == BLANK_LAST) begin
            state_s = DRIVE;
          end else begin
            state_s = BLANK;
          end
        end
        DRIVE: begin
          if (presc_r == PRESC_LAST) begin
            presc_s = {PW{1'b0}};
            state_s = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
            if (idx_r == IDX_LAST) begin
              idx_s   = {IW{1'b0}};
              frame_s = value_in;
              digit_s = value_in[3:0];
              fs_s    = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
              lz_s    = msd_index(value_in);
`endif
            end else begin
              idx_s   = idx_r + IW'(1);
              digit_s = frame_r[{idx_s, 2'b00} +: 4];
            end
          end else begin
            presc_s = presc_r + PW'(1);
            state_s = DRIVE;
          end
        end
        default: begin
          state_s = IDLE;
          presc_s = {PW{1'b0}};
          idx_s   = {IW{1'b0}};
        end
      endcase
    end
    // Anode decode uses next-state values so the registered anodes line up with the state.
    if (state_s == DRIVE) begin
`ifdef LEADING_ZERO_BLANK_EN
      if (idx_s <= lz_s) begin
        anode_s[idx_s] = 1'b0;
      end else begin
        anode_s = {NUM_DIGITS{1'b1}};
      end
`else
      anode_s[idx_s] = 1'b0;
`endif
    end else begin
      anode_s = {NUM_DIGITS{1'b1}};
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      presc_r <= {PW{1'b0}};
      idx_r   <= {IW{1'b0}};
      frame_r <= {(4*NUM_DIGITS){1'b0}};
      digit_r <= 4'h0;
      anode_r <= {NUM_DIGITS{1'b1}};
      fs_r    <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      lz_r    <= {IW{1'b0}};
`endif
    end else begin
      state_r <= state_s;
      presc_r <= presc_s;
      idx_r   <= idx_s;
      frame_r <= frame_s;
      digit_r <= digit_s;
      anode_r <= anode_s;
      fs_r    <= fs_s;
`ifdef LEADING_ZERO_BLANK_EN
      lz_r    <= lz_s;
`endif
    end
  end

  assign digit_out   = digit_r;
  assign anode_n     = anode_r;
  assign frame_start = fs_r;

endmodule
